matmul_sequencer: RTL and testbench

- Sequences a single 32-bit multiply-accumulate datapath through a full C = A x B product of two SIZE x SIZE matrices.
- A and B are held in external synchronous-read operand memories; results go to an external result memory.
- Sits between the control/host side (start/done handshake) and the operand/result RAMs.
- Replaces the fully parallel, per-element multiplier with a time-multiplexed, correct row-by-column schedule.

---
 rtl/matmul_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// matmul_sequencer
// Time-multiplexes one 32-bit multiply-accumulate datapath over a full
// C = A x B product of two SIZE x SIZE matrices held in synchronous-read RAMs.
//
// Memory interface protocol (fixed latency, no back-pressure):
//   rd_en high in a cycle presents a_addr/b_addr to both operand RAMs; the
//   RAMs return a_data/b_data exactly one cycle later. There is no ready
//   signal, so the sequencer never stalls. c_wr_en high in a cycle means
//   c_addr/c_data form one complete result write to be captured on that
//   cycle's rising edge. start is a one-cycle request accepted only in IDLE;
//   done is a one-cycle completion pulse.
//
// Pipeline per issued operand pair:
//   cycle n   : ISSUE  - rd_en with addresses from the i/j/k loop counters
//   cycle n+1 : MAC    - operands arrive, accumulator updates (tag r_vld)
//   cycle n+2 : WRITE  - visible on c_* when the MAC was tagged last (k==SIZE-1)

module matmul_sequencer #(
    parameter int SIZE   = 4,
    parameter int ADDR_W = ((SIZE * SIZE) > 1) ? $clog2(SIZE * SIZE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       a_data,
    input  logic [31:0]       b_data,
    output logic              c_wr_en,
    output logic [ADDR_W-1:0] c_addr,
    output logic [31:0]       c_data,
    output logic [1:0]        o_dbg_state
);

    // Loop counter width; a 1x1 product still needs a 1-bit counter.
    localparam int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Flat row-major element address row*SIZE+col.
    function automatic logic [ADDR_W-1:0] flat_addr(
        input logic [CNT_W-1:0] row,
        input logic [CNT_W-1:0] col
    );
        logic [31:0] w_sum;
        w_sum = 32'(row) * 32'(SIZE) + 32'(col);
        return w_sum[ADDR_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_drain_cnt;

    logic [CNT_W-1:0]   r_i;
    logic [CNT_W-1:0]   r_j;
    logic [CNT_W-1:0]   r_k;
    logic [CNT_W-1:0]   w_i_nxt;
    logic [CNT_W-1:0]   w_j_nxt;
    logic [CNT_W-1:0]   w_k_nxt;
    logic               w_last_issue;

    logic [ADDR_W-1:0]  r_a_addr;
    logic [ADDR_W-1:0]  r_b_addr;

    // Tag travelling with each issued pair into the MAC cycle
    logic               r_vld;
    logic               r_first;
    logic               r_last;
    logic [ADDR_W-1:0]  r_tag_c_addr;

    logic [31:0]        r_acc;
    logic [31:0]        w_prod;
    logic [31:0]        w_acc_nxt;

    logic               r_c_wr_en;
    logic [ADDR_W-1:0]  r_c_addr;
    logic [31:0]        r_c_data;

    logic               w_busy;
    logic               w_done;
    logic               w_issue;
    logic               w_accept;

    // ------------------------------------------------------------------
    // Loop counter successors: k innermost, then j, then i; all wrap.
    // ------------------------------------------------------------------
    assign w_k_nxt = (r_k == CNT_MAX) ? '0 : r_k + 1'b1;
    assign w_j_nxt = (r_k == CNT_MAX) ? ((r_j == CNT_MAX) ? '0 : r_j + 1'b1) : r_j;
    assign w_i_nxt = ((r_k == CNT_MAX) && (r_j == CNT_MAX))
                     ? ((r_i == CNT_MAX) ? '0 : r_i + 1'b1) : r_i;

    assign w_last_issue = (r_i == CNT_MAX) && (r_j == CNT_MAX) && (r_k == CNT_MAX);

    assign w_accept = (r_state == ST_IDLE) && start;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_busy  = 1'b1;
                w_issue = 1'b1;
                if (w_last_issue) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (r_drain_cnt) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Two-cycle drain: lets the last MAC and its write leave the pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drain_cnt <= 1'b0;
        end else begin
            r_drain_cnt <= (r_state == ST_DRAIN);
        end
    end

    // ------------------------------------------------------------------
    // Issue stage
    // ------------------------------------------------------------------

    // Loop counters advance once per issue and wrap to 0 after the last one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (w_issue) begin
            r_i <= w_i_nxt;
            r_j <= w_j_nxt;
            r_k <= w_k_nxt;
        end
    end

    // Operand addresses track the counters during ISSUE and hold afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_addr <= '0;
            r_b_addr <= '0;
        end else if (w_accept) begin
            r_a_addr <= '0;
            r_b_addr <= '0;
        end else if (w_issue && !w_last_issue) begin
            r_a_addr <= flat_addr(w_i_nxt, w_k_nxt);
            r_b_addr <= flat_addr(w_k_nxt, w_j_nxt);
        end
    end

    // Tag each issue so the MAC knows when to clear and when to write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld        <= 1'b0;
            r_first      <= 1'b0;
            r_last       <= 1'b0;
            r_tag_c_addr <= '0;
        end else begin
            r_vld <= w_issue;
            if (w_issue) begin
                r_first      <= (r_k == '0);
                r_last       <= (r_k == CNT_MAX);
                r_tag_c_addr <= flat_addr(r_i, r_j);
            end
        end
    end

    // ------------------------------------------------------------------
    // MAC and write stages
    // ------------------------------------------------------------------

    // Product truncated to 32 bits; sum wraps modulo 2^32
    assign w_prod    = a_data * b_data;
    assign w_acc_nxt = (r_first ? 32'd0 : r_acc) + w_prod;

    // Accumulator: restarts on the first term of every element
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (r_vld) begin
            r_acc <= w_acc_nxt;
        end
    end

    // Result write: one-cycle strobe after the last term of an element
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_wr_en <= 1'b0;
            r_c_addr  <= '0;
            r_c_data  <= '0;
        end else begin
            r_c_wr_en <= r_vld && r_last;
            if (r_vld && r_last) begin
                r_c_addr <= r_tag_c_addr;
                r_c_data <= w_acc_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy        = w_busy;
    assign done        = w_done;
    assign rd_en       = w_issue;
    assign a_addr      = r_a_addr;
    assign b_addr      = r_b_addr;
    assign c_wr_en     = r_c_wr_en;
    assign c_addr      = r_c_addr;
    assign c_data      = r_c_data;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: a SIZE=2 and a SIZE=4 instance share
// one clock and reset, each with its own synchronous-read operand memories.
module tb_matmul_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- SIZE=2 instance ----------------
  logic        start2, busy2, done2, rd2, wr2;
  logic [1:0]  a_addr2, b_addr2, c_addr2, st2;
  logic [31:0] a_q2, b_q2, c_data2;
  logic [31:0] mem_a2 [4];
  logic [31:0] mem_b2 [4];

  matmul_sequencer #(.SIZE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .rd_en(rd2), .a_addr(a_addr2), .b_addr(b_addr2),
    .a_data(a_q2), .b_data(b_q2),
    .c_wr_en(wr2), .c_addr(c_addr2), .c_data(c_data2), .o_dbg_state(st2)
  );

  always @(posedge clk) begin
    if (rd2) begin
      a_q2 <= mem_a2[a_addr2];
      b_q2 <= mem_b2[b_addr2];
    end
  end

  // ---------------- SIZE=4 instance ----------------
  logic        start4, busy4, done4, rd4, wr4;
  logic [3:0]  a_addr4, b_addr4, c_addr4;
  logic [1:0]  st4;
  logic [31:0] a_q4, b_q4, c_data4;
  logic [31:0] mem_a4 [16];
  logic [31:0] mem_b4 [16];
  logic [31:0] exp4 [16];

  matmul_sequencer #(.SIZE(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
    .rd_en(rd4), .a_addr(a_addr4), .b_addr(b_addr4),
    .a_data(a_q4), .b_data(b_q4),
    .c_wr_en(wr4), .c_addr(c_addr4), .c_data(c_data4), .o_dbg_state(st4)
  );

  always @(posedge clk) begin
    if (rd4) begin
      a_q4 <= mem_a4[a_addr4];
      b_q4 <= mem_b4[b_addr4];
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Golden 4x4 product, 32-bit wrapping arithmetic
  task automatic build_model4();
    logic [31:0] s;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 32'd0;
        for (int k = 0; k < 4; k++) s = s + mem_a4[i*4+k] * mem_b4[k*4+j];
        exp4[i*4+j] = s;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered at a negedge. Cycle T is the one whose closing edge samples start;
  // the n-th following negedge observes cycle T+n. With hold set, start stays
  // high so a new run begins every 12 cycles (p is the position within a run).
  task automatic run2(input bit hold, input bit pulses, input int ncyc);
    int p;
    int m;
    int widx;
    bit is_wr;
    logic [31:0] e;
    widx = 0;
    start2 = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= ncyc; n++) begin
      p = hold ? ((n - 1) % 12) + 1 : n;
      is_wr = (p == 4) || (p == 6) || (p == 8) || (p == 10);
      check("busy2", 32'(busy2), 32'(p >= 1 && p <= 10));
      check("done2", 32'(done2), 32'(p == 11));
      check("rd_en2", 32'(rd2), 32'(p <= 8));
      check("wr2", 32'(wr2), 32'(is_wr));
      if (p <= 8) begin
        m = p - 1;
        check("a_addr2", 32'(a_addr2), 32'((m / 4) * 2 + (m % 2)));
        check("b_addr2", 32'(b_addr2), 32'((m % 2) * 2 + ((m / 2) % 2)));
      end
      if (is_wr) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("c_addr2", 32'(c_addr2), 32'(widx % 4));
        check("c_data2", c_data2, e);
        widx++;
      end
      if (hold) start2 = (n != ncyc);
      else      start2 = pulses && (n == 5 || n == 9 || n == 11);
      @(negedge clk);
    end
    start2 = 1'b0;
    check("sb2_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run4(input int ncyc);
    int m;
    bit is_wr;
    logic [31:0] e;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      is_wr = (n >= 6) && (n <= 66) && (((n - 6) % 4) == 0);
      check("busy4", 32'(busy4), 32'(n >= 1 && n <= 66));
      check("done4", 32'(done4), 32'(n == 67));
      check("rd_en4", 32'(rd4), 32'(n <= 64));
      check("wr4", 32'(wr4), 32'(is_wr));
      if (n <= 64) begin
        m = n - 1;
        check("a_addr4", 32'(a_addr4), 32'((m / 16) * 4 + (m % 4)));
        check("b_addr4", 32'(b_addr4), 32'((m % 4) * 4 + ((m / 4) % 4)));
      end
      if (is_wr) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("c_addr4", 32'(c_addr4), 32'((n - 6) / 4));
        check("c_data4", c_data4, e);
      end
      @(negedge clk);
    end
    check("sb4_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle4(input string tag);
    check({tag, "_busy"}, 32'(busy4), 32'd0);
    check({tag, "_done"}, 32'(done4), 32'd0);
    check({tag, "_rd"}, 32'(rd4), 32'd0);
    check({tag, "_wr"}, 32'(wr4), 32'd0);
    check({tag, "_a_addr"}, 32'(a_addr4), 32'd0);
    check({tag, "_b_addr"}, 32'(b_addr4), 32'd0);
    check({tag, "_c_addr"}, 32'(c_addr4), 32'd0);
    check({tag, "_c_data"}, c_data4, 32'd0);
    check({tag, "_state"}, 32'(st4), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    start2 = 1'b0;
    start4 = 1'b0;
    for (int x = 0; x < 4; x++) begin
      mem_a2[x] = 32'd0;
      mem_b2[x] = 32'd0;
    end
    for (int x = 0; x < 16; x++) begin
      mem_a4[x] = 32'h9E37_79B9 * 32'(x + 1);
      mem_b4[x] = 32'h7FFF_FFF0 + 32'(x * 3);
    end
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy2", 32'(busy2), 32'd0);
    check("rst_done2", 32'(done2), 32'd0);
    check("rst_rd2", 32'(rd2), 32'd0);
    check("rst_wr2", 32'(wr2), 32'd0);
    check("rst_c_data2", c_data2, 32'd0);
    check("rst_state2", 32'(st2), 32'd0);
    check_idle4("rst4");
    rst = 1'b0;
    @(negedge clk);

    // 2x2: identity x {1,2;3,4}
    mem_a2[0] = 32'd1; mem_a2[1] = 32'd0; mem_a2[2] = 32'd0; mem_a2[3] = 32'd1;
    mem_b2[0] = 32'd1; mem_b2[1] = 32'd2; mem_b2[2] = 32'd3; mem_b2[3] = 32'd4;
    exp_q.push_back(32'd1); exp_q.push_back(32'd2);
    exp_q.push_back(32'd3); exp_q.push_back(32'd4);
    run2(1'b0, 1'b0, 14);

    // 2x2 wrap: products 0xFFFFFFFE, sums 0xFFFFFFFC
    for (int x = 0; x < 4; x++) begin
      mem_a2[x] = 32'hFFFF_FFFF;
      mem_b2[x] = 32'd2;
      exp_q.push_back(32'hFFFF_FFFC);
    end
    run2(1'b0, 1'b0, 14);

    // 2x2 {1,2;3,4} x {5,6;7,8} = {19,22;43,50}, stray starts in ISSUE/DRAIN/DONE
    mem_a2[0] = 32'd1; mem_a2[1] = 32'd2; mem_a2[2] = 32'd3; mem_a2[3] = 32'd4;
    mem_b2[0] = 32'd5; mem_b2[1] = 32'd6; mem_b2[2] = 32'd7; mem_b2[3] = 32'd8;
    exp_q.push_back(32'd19); exp_q.push_back(32'd22);
    exp_q.push_back(32'd43); exp_q.push_back(32'd50);
    run2(1'b0, 1'b1, 14);

    // Back-to-back with start held: two identical runs, no carry-over
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(32'd19); exp_q.push_back(32'd22);
      exp_q.push_back(32'd43); exp_q.push_back(32'd50);
    end
    run2(1'b1, 1'b0, 24);

    // 4x4 full product against the model
    build_model4();
    for (int x = 0; x < 16; x++) exp_q.push_back(exp4[x]);
    run4(70);

    // 4x4 aborted by reset at T+6, then a fresh product
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      check("pre_rst_busy4", 32'(busy4), 32'd1);
      check("pre_rst_rd4", 32'(rd4), 32'd1);
      check("pre_rst_wr4", 32'(wr4), 32'(n == 6));
      if (n == 6) check("pre_rst_c_data4", c_data4, exp4[0]);
      if (n == 6) rst = 1'b1;
      @(negedge clk);
    end
    check_idle4("abort_t7");
    rst = 1'b0;
    @(negedge clk);
    check_idle4("abort_t8");

    for (int x = 0; x < 16; x++) begin
      mem_a4[x] = 32'(x + 1);
      mem_b4[x] = 32'(16 - x) * 32'h0101_0101;
    end
    build_model4();
    for (int x = 0; x < 16; x++) exp_q.push_back(exp4[x]);
    run4(70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
